// File: rtl/vga_console_writer.sv
// Terminal-style writer: turns a character stream into glyph writes on the VGA text buffer
// bus, tracks an 80x30 cursor, handles control codes and forwards colour/debug register writes.
module vga_console_writer #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 15,
    parameter int N_COL            = 80,
    parameter int N_ROW            = 30,
    parameter logic [C_AXI_ADDR_WIDTH-1:0] BUF_BASE = 15'h4000,
    parameter logic [C_AXI_ADDR_WIDTH-1:0] REG_BASE = 15'h2000,
    parameter int WR_PULSE         = 2,
    parameter int WR_SLOT          = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          char_valid_i,
    input  logic [7:0]                    char_data_i,
    output logic                          char_ready_o,
    input  logic                          cfg_valid_i,
    input  logic [2:0]                    cfg_sel_i,
    input  logic [3:0]                    cfg_data_i,
    output logic                          cfg_ready_o,
    output logic [C_AXI_ADDR_WIDTH-1:0]   axil_waddr_o,
    output logic [C_AXI_DATA_WIDTH-1:0]   axil_wdata_o,
    output logic [3:0]                    axil_wstrb_o,
    output logic                          axil_wready_o,
    output logic [6:0]                    cursor_col_o,
    output logic [4:0]                    cursor_row_o,
    output logic                          busy_o
);

    localparam int AW = C_AXI_ADDR_WIDTH;
    localparam int CW = $clog2(WR_SLOT);
    localparam logic [CW-1:0] SLOT_LAST = CW'(WR_SLOT - 1);
    localparam logic [6:0]    COL_LAST  = 7'(N_COL - 1);
    localparam logic [4:0]    ROW_LAST  = 5'(N_ROW - 1);
    localparam logic [9:0]    CLR_LAST  = 10'(N_COL * N_ROW / 4 - 1);
    localparam logic [31:0]   BLANK4    = 32'h20202020;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [9:0]      clr_q, clr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     data_q, data_d;
    logic [3:0]      strb_q, strb_d;
    logic [6:0]      col_q, col_d, pcol_q, pcol_d;
    logic [4:0]      row_q, row_d, prow_q, prow_d;

    logic [11:0]     tile_cur, tile_bs;
    logic [6:0]      adv_col;
    logic [4:0]      adv_row, nl_row;
    logic            is_print;

    assign tile_cur = 12'(row_q) * 12'(N_COL) + 12'(col_q);
    assign tile_bs  = tile_cur - 12'd1;
    assign nl_row   = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;
    assign adv_col  = (col_q == COL_LAST) ? 7'd0 : col_q + 7'd1;
    assign adv_row  = (col_q == COL_LAST) ? nl_row : row_q;
    assign is_print = (char_data_i >= 8'h20) && (char_data_i <= 8'h7E);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            clr_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            pcol_q  <= '0;
            prow_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clr_q   <= clr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pcol_q  <= pcol_d;
            prow_q  <= prow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_d   = clr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        strb_d  = strb_q;
        col_d   = col_q;
        row_d   = row_q;
        pcol_d  = pcol_q;
        prow_d  = prow_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (cfg_valid_i) begin
                    if (cfg_sel_i != 3'd7) begin
                        addr_d  = REG_BASE + {{(AW-5){1'b0}}, cfg_sel_i, 2'b00};
                        data_d  = {28'd0, cfg_data_i};
                        strb_d  = 4'b0001;
                        pcol_d  = col_q;
                        prow_d  = row_q;
                        state_d = S_WRITE;
                    end
                end else if (char_valid_i) begin
                    if (is_print) begin
                        addr_d  = BUF_BASE + {{(AW-12){1'b0}}, tile_cur[11:2], 2'b00};
                        data_d  = {4{1'b0, char_data_i[6:0]}};
                        strb_d  = 4'b0001 << tile_cur[1:0];
                        pcol_d  = adv_col;
                        prow_d  = adv_row;
                        state_d = S_WRITE;
                    end else if (char_data_i == 8'h0D) begin
                        col_d = '0;
                    end else if (char_data_i == 8'h0A) begin
                        col_d = '0;
                        row_d = nl_row;
                    end else if (char_data_i == 8'h08) begin
                        // Backspace blanks the cell it moves onto; at column 0 it does nothing.
                        if (col_q != 7'd0) begin
                            addr_d  = BUF_BASE + {{(AW-12){1'b0}}, tile_bs[11:2], 2'b00};
                            data_d  = BLANK4;
                            strb_d  = 4'b0001 << tile_bs[1:0];
                            pcol_d  = col_q - 7'd1;
                            prow_d  = row_q;
                            state_d = S_WRITE;
                        end
                    end else if (char_data_i == 8'h0C) begin
                        addr_d  = BUF_BASE;
                        data_d  = BLANK4;
                        strb_d  = 4'hF;
                        clr_d   = '0;
                        state_d = S_CLEAR;
                    end
                end
            end
            S_WRITE: begin
                if (cnt_q == SLOT_LAST) begin
                    cnt_d   = '0;
                    col_d   = pcol_q;
                    row_d   = prow_q;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CLEAR: begin
                if (cnt_q == SLOT_LAST) begin
                    cnt_d = '0;
                    if (clr_q == CLR_LAST) begin
                        col_d   = '0;
                        row_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        clr_d  = clr_q + 10'd1;
                        addr_d = addr_q + {{(AW-3){1'b0}}, 3'd4};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs are only meaningful inside a slot; they read as zero otherwise.
    assign busy_o        = (state_q != S_IDLE);
    assign axil_waddr_o  = busy_o ? addr_q : '0;
    assign axil_wdata_o  = busy_o ? C_AXI_DATA_WIDTH'(data_q) : '0;
    assign axil_wstrb_o  = busy_o ? strb_q : 4'd0;
    assign axil_wready_o = busy_o && (int'(cnt_q) < WR_PULSE);
    assign char_ready_o  = (state_q == S_IDLE) && !rst_i;
    assign cfg_ready_o   = (state_q == S_IDLE) && !rst_i;
    assign cursor_col_o  = col_q;
    assign cursor_row_o  = row_q;

endmodule

// File: tb/tb_vga_console_writer.sv
// Bench for vga_console_writer: directed vector table, hand sequences for wrap/clear/priority/reset,
// and random traffic checked against a cursor/address model.
module tb_vga_console_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic        char_ready;
    logic        cfg_valid = 1'b0;
    logic [2:0]  cfg_sel = 3'd0;
    logic [3:0]  cfg_data = 4'd0;
    logic        cfg_ready;
    logic [14:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wready;
    logic [6:0]  cur_col;
    logic [4:0]  cur_row;
    logic        busy;

    always #5 clk = ~clk;

    vga_console_writer dut (
        .clk_i(clk), .rst_i(rst),
        .char_valid_i(char_valid), .char_data_i(char_data), .char_ready_o(char_ready),
        .cfg_valid_i(cfg_valid), .cfg_sel_i(cfg_sel), .cfg_data_i(cfg_data), .cfg_ready_o(cfg_ready),
        .axil_waddr_o(waddr), .axil_wdata_o(wdata), .axil_wstrb_o(wstrb), .axil_wready_o(wready),
        .cursor_col_o(cur_col), .cursor_row_o(cur_row), .busy_o(busy)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    int busy_cyc = 0, wr_cyc = 0, hold_err = 0, idle_err = 0;
    logic [50:0] wq[$];
    logic [50:0] cur_ent = '0;
    logic        prev_wr = 1'b0;
    int mrow = 0, mcol = 0;

    typedef struct {
        logic [7:0]  code;
        bit          wr;
        logic [14:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          row;
        int          col;
    } vec_t;
    vec_t vecs[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // Bus monitor: one queue entry per slot (wready rising), plus hold and idle-zero checks.
    always @(negedge clk) begin
        if (rst) begin
            prev_wr = 1'b0;
        end else begin
            if (busy) busy_cyc++;
            if (wready) wr_cyc++;
            if (wready && !prev_wr) begin
                cur_ent = {waddr, wdata, wstrb};
                wq.push_back(cur_ent);
            end else if (busy && ({waddr, wdata, wstrb} !== cur_ent)) begin
                hold_err++;
            end
            if (!busy && (waddr != 0 || wdata != 0 || wstrb != 0 || wready)) idle_err++;
            prev_wr = wready;
        end
    end

    function automatic logic [50:0] mk(input int t, input logic [7:0] g);
        logic [14:0] a;
        logic [3:0]  s;
        a = 15'(32'h4000 + (t / 4) * 4);
        s = 4'(1 << (t % 4));
        return {a, g, g, g, g, s};
    endfunction

    function automatic bit model_char(input logic [7:0] c, output logic [50:0] ent);
        bit w;
        w = 1'b0;
        ent = '0;
        if (c >= 8'h20 && c <= 8'h7E) begin
            w = 1'b1;
            ent = mk(mrow * 80 + mcol, c);
            mcol++;
            if (mcol == 80) begin mcol = 0; mrow = (mrow + 1) % 30; end
        end else if (c == 8'h0D) begin
            mcol = 0;
        end else if (c == 8'h0A) begin
            mcol = 0;
            mrow = (mrow + 1) % 30;
        end else if (c == 8'h08 && mcol > 0) begin
            mcol--;
            w = 1'b1;
            ent = mk(mrow * 80 + mcol, 8'h20);
        end
        return w;
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!char_ready && n < 3000) begin @(negedge clk); n++; end
        if (!char_ready) chk("ready_timeout", char_ready, 1);
        wq.delete();
        busy_cyc = 0;
        wr_cyc = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (busy && n < 3000);
        if (busy) chk("busy_timeout", busy, 0);
    endtask

    task automatic xfer_char(input logic [7:0] c);
        wait_ready();
        char_valid = 1'b1;
        char_data = c;
        @(posedge clk);
        #1 char_valid = 1'b0;
        wait_idle();
    endtask

    task automatic xfer_cfg(input logic [2:0] s, input logic [3:0] v);
        wait_ready();
        cfg_valid = 1'b1;
        cfg_sel = s;
        cfg_data = v;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        wait_idle();
    endtask

    task automatic check_result(input string nm, input bit w, input logic [50:0] e,
                                input int er, input int ec);
        chk({nm, "_nwr"}, wq.size(), w);
        if (w && wq.size() == 1) chk({nm, "_ent"}, wq[0], e);
        chk({nm, "_cyc"}, {busy_cyc, wr_cyc}, w ? {32'd4, 32'd2} : 64'd0);
        chk({nm, "_cur"}, {cur_row, cur_col}, {5'(er), 7'(ec)});
    endtask

    task automatic run_char(input logic [7:0] c);
        logic [50:0] e;
        bit w;
        w = model_char(c, e);
        xfer_char(c);
        check_result($sformatf("chr%02h", c), w, e, mrow, mcol);
    endtask

    task automatic run_cfg(input logic [2:0] s, input logic [3:0] v);
        logic [50:0] e;
        e = {15'h2000 + {10'd0, s, 2'b00}, 28'd0, v, 4'b0001};
        xfer_cfg(s, v);
        check_result($sformatf("cfg%0d", s), s != 3'd7, e, mrow, mcol);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mrow = 0;
        mcol = 0;
    endtask

    initial begin
        int bad, n, r;
        logic [50:0] e;
        logic [7:0] c;

        vecs[0]  = '{8'h41, 1'b1, 15'h4000, 32'h41414141, 4'h1, 0, 1};
        vecs[1]  = '{8'h61, 1'b1, 15'h4000, 32'h61616161, 4'h2, 0, 2};
        vecs[2]  = '{8'h62, 1'b1, 15'h4000, 32'h62626262, 4'h4, 0, 3};
        vecs[3]  = '{8'h63, 1'b1, 15'h4000, 32'h63636363, 4'h8, 0, 4};
        vecs[4]  = '{8'h64, 1'b1, 15'h4004, 32'h64646464, 4'h1, 0, 5};
        vecs[5]  = '{8'h42, 1'b1, 15'h4004, 32'h42424242, 4'h2, 0, 6};
        vecs[6]  = '{8'h08, 1'b1, 15'h4004, 32'h20202020, 4'h2, 0, 5};
        vecs[7]  = '{8'h0D, 1'b0, 15'h0,    32'h0,        4'h0, 0, 0};
        vecs[8]  = '{8'h08, 1'b0, 15'h0,    32'h0,        4'h0, 0, 0};
        vecs[9]  = '{8'h0A, 1'b0, 15'h0,    32'h0,        4'h0, 1, 0};
        vecs[10] = '{8'h7F, 1'b0, 15'h0,    32'h0,        4'h0, 1, 0};
        vecs[11] = '{8'h9B, 1'b0, 15'h0,    32'h0,        4'h0, 1, 0};
        vecs[12] = '{8'h7E, 1'b1, 15'h4050, 32'h7E7E7E7E, 4'h1, 1, 1};
        vecs[13] = '{8'h20, 1'b1, 15'h4050, 32'h20202020, 4'h2, 1, 2};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_bus", {waddr, wdata, wstrb, wready}, 52'd0);
        chk("rst_ready_busy", {char_ready, cfg_ready, busy}, 3'b000);
        chk("rst_cursor", {cur_row, cur_col}, 12'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", {char_ready, cfg_ready}, 2'b11);

        // Directed vector table from (0,0)
        foreach (vecs[i]) begin
            xfer_char(vecs[i].code);
            check_result($sformatf("vec%0d", i), vecs[i].wr,
                         {vecs[i].addr, vecs[i].data, vecs[i].strb}, vecs[i].row, vecs[i].col);
        end

        // Line wrap at column 79 and screen wrap at (29,79)
        do_reset();
        for (int i = 0; i < 80; i++) run_char(8'(8'h21 + i % 90));
        run_char(8'h58);
        chk("wrap81_ent", wq.size() > 0 ? wq[0] : 51'd0, {15'h4050, 32'h58585858, 4'h1});
        chk("wrap81_cur", {cur_row, cur_col}, {5'd1, 7'd1});
        for (int i = 0; i < 28; i++) run_char(8'h0A);
        for (int i = 0; i < 79; i++) run_char(8'(8'h30 + i % 40));
        run_char(8'h5A);
        chk("lastcell_ent", wq.size() > 0 ? wq[0] : 51'd0, {15'h495C, 32'h5A5A5A5A, 4'h8});
        chk("lastcell_cur", {cur_row, cur_col}, 12'd0);

        // Backspace at (3,10) and at column 0
        for (int i = 0; i < 3; i++) run_char(8'h0A);
        for (int i = 0; i < 10; i++) run_char(8'h61);
        run_char(8'h08);
        chk("bs_ent", wq.size() > 0 ? wq[0] : 51'd0, {15'h40F8, 32'h20202020, 4'h2});
        chk("bs_cur", {cur_row, cur_col}, {5'd3, 7'd9});
        run_char(8'h0D);
        run_char(8'h08);

        // Clear screen
        run_char(8'h47);
        xfer_char(8'h0C);
        bad = 0;
        foreach (wq[k])
            if (wq[k] !== {15'(32'h4000 + 4 * k), 32'h20202020, 4'hF}) bad++;
        chk("clr_count", wq.size(), 600);
        chk("clr_words_bad", bad, 0);
        chk("clr_cycles", {busy_cyc, wr_cyc}, {32'd2400, 32'd1200});
        chk("clr_cursor", {cur_row, cur_col}, 12'd0);
        mrow = 0;
        mcol = 0;

        // cfg beats char in the same cycle
        run_char(8'h41);
        wait_ready();
        cfg_valid = 1'b1; cfg_sel = 3'd1; cfg_data = 4'hA;
        char_valid = 1'b1; char_data = 8'h43;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!char_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 char_valid = 1'b0;
        wait_idle();
        void'(model_char(8'h43, e));
        chk("prio_n", wq.size(), 2);
        chk("prio_cfg", wq.size() > 0 ? wq[0] : 51'd0, {15'h2004, 32'h0000000A, 4'h1});
        chk("prio_chr", wq.size() > 1 ? wq[1] : 51'd0, e);
        chk("prio_cur", {cur_row, cur_col}, {5'(mrow), 7'(mcol)});

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 10) run_cfg(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            else if (r < 60) run_char(8'($urandom_range(32, 126)));
            else if (r < 70) run_char(8'h0D);
            else if (r < 78) run_char(8'h0A);
            else if (r < 90) run_char(8'h08);
            else begin
                c = (r < 95) ? 8'($urandom_range(127, 255)) : 8'($urandom_range(0, 7));
                run_char(c);
            end
        end

        // Reset in the middle of a clear
        run_char(8'h51);
        wait_ready();
        char_valid = 1'b1; char_data = 8'h0C;
        @(posedge clk);
        #1 char_valid = 1'b0;
        repeat (100) @(negedge clk);
        n = 0;
        while (!wready && n < 10) begin @(negedge clk); n++; end
        chk("midclr_active", {busy, wready}, 2'b11);
        rst = 1'b1;
        #1;
        chk("midclr_rst_bus", {waddr, wdata, wstrb, wready, busy}, 53'd0);
        chk("midclr_rst_cursor", {cur_row, cur_col}, 12'd0);
        chk("midclr_rst_ready", {char_ready, cfg_ready}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        wq.delete();
        busy_cyc = 0;
        repeat (20) @(negedge clk);
        chk("no_resume", {32'(wq.size()), busy_cyc}, 64'd0);
        mrow = 0;
        mcol = 0;
        run_char(8'h52);

        chk("hold_errs", hold_err, 0);
        chk("idle_errs", idle_err, 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
